// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet lock that shares one uart_tx serializer
// between NUM_REQ valid/ready byte streams, with a tx_busy start-up watchdog.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned ID_W         = 2,
    parameter int unsigned BUSY_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 active,
    output logic                 timeout_err
);

    localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT);
    // The counter starts the cycle after tx_start, so the watchdog trips
    // BUSY_TIMEOUT-2 so that timeout_err lands BUSY_TIMEOUT cycles after tx_start.
    localparam int unsigned TO_LAST = BUSY_TIMEOUT - 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               lock, lock_d;
    logic [ID_W-1:0]    rr_ptr, rr_d;
    logic               tx_start_d;
    logic [7:0]         tx_data_d;
    logic [ID_W-1:0]    grant_d;
    logic               active_d;
    logic               timeout_d;

    logic [NUM_REQ-1:0] cand;
    logic               win_vld;
    logic [ID_W-1:0]    win;
    logic [7:0]         win_byte;

    // Round-robin search starting one past the last winner, restricted to the
    // locked lane while a packet is open.
    always_comb begin
        cand     = req_valid & (lock ? (NUM_REQ'(1) << grant_id) : '1);
        win_vld  = 1'b0;
        win      = '0;
        win_byte = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            int unsigned idx;
            idx = (32'(rr_ptr) + k) % NUM_REQ;
            if (!win_vld && cand[ID_W'(idx)]) begin
                win_vld = 1'b1;
                win     = ID_W'(idx);
            end
        end
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (win == ID_W'(k)) begin
                win_byte = req_data[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        lock_d    = lock;
        rr_d      = rr_ptr;
        tx_data_d = tx_data;
        grant_d   = grant_id;
        active_d  = active;
        timeout_d = 1'b0;
        req_ready = '0;

        case (state)
            IDLE: begin
                if (!tx_busy && win_vld) begin
                    req_ready = NUM_REQ'(1) << win;
                    tx_data_d = win_byte;
                    grant_d   = win;
                    rr_d      = win;
                    active_d  = 1'b1;
                    lock_d    = ~req_last[win];
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt == CNT_W'(TO_LAST)) begin
                    timeout_d = 1'b1;
                    active_d  = 1'b0;
                    lock_d    = 1'b0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    active_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        tx_start_d = (state_d == LAUNCH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            lock        <= 1'b0;
            rr_ptr      <= ID_W'(NUM_REQ - 1);
            tx_start    <= 1'b0;
            tx_data     <= '0;
            grant_id    <= '0;
            active      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            lock        <= lock_d;
            rr_ptr      <= rr_d;
            tx_start    <= tx_start_d;
            tx_data     <= tx_data_d;
            grant_id    <= grant_d;
            active      <= active_d;
            timeout_err <= timeout_d;
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares a single uart_tx serializer between NUM_REQ byte-stream requesters.
- Each requester offers one byte at a time over a valid/ready handshake.
- Round-robin arbitration, with a packet lock: a requester keeps the grant until it sends a byte flagged last.
- Drives uart_tx's tx_start/tx_data and sequences on its tx_busy; sits between the system message sources and uart_tx.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of grant_id; must equal ceil(log2(NUM_REQ)).
- BUSY_TIMEOUT, 8, cycles allowed for tx_busy to rise after tx_start before the launch is declared failed.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous active-high reset.
- req_valid  input  NUM_REQ  bit i: requester i has a byte on its lane.
- req_data  input  NUM_REQ*8  lane i at bits [8i+7:8i].
- req_last  input  NUM_REQ  bit i: lane-i byte ends its packet.
- req_ready  output  NUM_REQ  one-hot, one-cycle pulse: lane-i byte accepted this cycle.
- tx_start  output  1  one-cycle launch pulse to uart_tx.
- tx_data  output  8  byte to uart_tx; stable from accept until the next accept.
- tx_busy  input  1  from uart_tx; high while a frame is on the line.
- grant_id  output  ID_W  index of the requester owning the current or last byte.
- active  output  1  high from accept until tx_busy falls (or timeout).
- timeout_err  output  1  one-cycle pulse when tx_busy fails to rise within BUSY_TIMEOUT.

Behaviour:
- Reset (async, any state) forces:
  - tx_start=0, tx_data=0, req_ready=0, grant_id=0, active=0, timeout_err=0.
  - FSM to IDLE, lock=0, rr_ptr=NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-frame abandons the byte; no retry after release.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Arbitrates only when tx_busy=0 and some eligible req_valid=1.
  - Eligible set: if lock=1, only grant_id; otherwise all lanes.
  - Winner: first valid lane searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - In the arbitration cycle: req_ready[g]=1; tx_data<=lane g; grant_id<=g; rr_ptr<=g; active<=1; lock<=~req_last[g]. Next state LAUNCH.
  - If locked and the locked lane has valid=0: wait in IDLE; other lanes are never served (no lock timeout).
- LAUNCH: tx_start=1 for exactly one cycle -> WAIT_BUSY; clear the timeout counter.
- WAIT_BUSY:
  - tx_busy=1 -> WAIT_DONE.
  - Otherwise count; on count reaching BUSY_TIMEOUT: timeout_err pulse, active<=0, lock<=0 -> IDLE.
- WAIT_DONE: on tx_busy=0 -> active<=0 -> IDLE. The earliest next accept is the cycle after this return, so inter-byte gap ≥1 idle cycle.
- Throughput: accept-to-tx_start latency is 1 cycle; exactly one byte in flight; no internal buffering.
- req_ready is never asserted for a lane whose req_valid=0. A requester must hold valid/data/last stable until it sees ready.
- Simultaneous valids with no lock: the rotation guarantees every lane is served within NUM_REQ packets.
- If tx_busy=1 while in IDLE (external or stale), do not arbitrate.
- tx_start is never asserted outside LAUNCH.

Test Plan:
- Single byte: reset 100 ns; lane0 valid, data=0xA5, last=1 -> ready[0] pulse one cycle, tx_start next cycle with tx_data=0xA5, serial line carries 0xA5 LSB first, active falls with tx_busy, grant_id=0.
- Round-robin: lanes 0,1,2 valid with 0x11/0x22/0x33, all last=1, held valid until accepted -> bytes sent in order 0x11, 0x22, 0x33; lane 0 reasserted after the first byte waits behind lanes 1 and 2.
- Packet lock: lane 2 sends 0x48,0x49 (last=0) then 0x0A (last=1) while lane 0 holds 0x55 valid -> all three lane-2 bytes precede 0x55.
- Timeout: tx_busy forced 0 by a stub -> timeout_err pulses exactly BUSY_TIMEOUT cycles after tx_start; lock cleared; next valid lane accepted.
- Reset mid-frame: assert reset during WAIT_DONE -> all outputs zero immediately (async); after release, lane 0 is arbitrated first.
- Busy guard: tx_busy held 1 in IDLE with lane 1 valid -> no ready and no tx_start until tx_busy drops, then ready[1] next cycle.
